// File: rtl/fun_sched_pkg.sv
// Shared types and widths for the fun-unit job scheduler.
package fun_sched_pkg;

  localparam int unsigned OP_W  = 8;
  localparam int unsigned RES_W = 11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } job_t;

  // Occupancy counter width: must represent 0..depth inclusive
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fun_sched_if.sv
// Request, response and fun-unit handshake signals of the scheduler.
interface fun_sched_if;
  import fun_sched_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [OP_W-1:0]  req_a;
  logic [OP_W-1:0]  req_b;

  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_data;

  logic             fun_start;
  logic [OP_W-1:0]  fun_a;
  logic [OP_W-1:0]  fun_b;
  logic             fun_busy;
  logic [RES_W-1:0] fun_result;

  // Environment side: job producer, result consumer and the fun unit itself
  modport master (
    output req_valid, req_a, req_b, res_ready, fun_busy, fun_result,
    input  req_ready, res_valid, res_data, fun_start, fun_a, fun_b
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_a, req_b, res_ready, fun_busy, fun_result,
    output req_ready, res_valid, res_data, fun_start, fun_a, fun_b
  );

endinterface

// File: rtl/sync_fifo.sv
// In-order request FIFO; ready and level are registered so the producer
// never sees a combinational path from the consumer side.
module sync_fifo
  import fun_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head_c,
  output logic [lvl_w(DEPTH)-1:0]  o_level,
  output logic                     o_ready
);

  localparam int unsigned LVL_W = lvl_w(DEPTH);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_ready;

  logic             w_push;
  logic             w_pop;
  logic [LVL_W-1:0] w_level_nxt;

  assign w_push = i_push && r_ready;
  assign w_pop  = i_pop && (r_level != '0);

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LVL_W'(1);
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - LVL_W'(1);
    end
  end

  // Power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != LVL_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head_c = r_mem[r_rd_ptr];
  assign o_level  = r_level;
  assign o_ready  = r_ready;

endmodule

// File: rtl/fun_sched.sv
// Queues (a, b) jobs, runs them one at a time on the fun unit with a
// watchdog, and returns results in order through a one-entry result slot.
module fun_sched
  import fun_sched_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  fun_sched_if.slave               bus,
  output logic                     timeout_err,
  output logic [CNT_W-1:0]         jobs_done,
  output logic [lvl_w(DEPTH)-1:0]  fifo_level
);

  localparam int unsigned LVL_W = lvl_w(DEPTH);
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  state_t           r_state;
  state_t           w_state_nxt;

  job_t             w_head;
  logic [LVL_W-1:0] w_level;
  logic             w_req_ready;
  logic             w_pop;
  logic             w_load;
  logic             w_abort;

  logic [OP_W-1:0]  r_cur_a;
  logic [OP_W-1:0]  r_cur_b;
  logic             r_seen_busy;
  logic [WD_W-1:0]  r_wdog;
  logic             r_fun_start;
  logic             r_res_valid;
  logic [RES_W-1:0] r_res_data;
  logic             r_timeout_err;
  logic [CNT_W-1:0] r_jobs_done;

  sync_fifo #(
    .WIDTH (2 * OP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (bus.req_valid),
    .i_data   ({bus.req_a, bus.req_b}),
    .i_pop    (w_pop),
    .o_head_c (w_head),
    .o_level  (w_level),
    .o_ready  (w_req_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_level != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Completion wins over a watchdog expiry in the same cycle
        if (r_seen_busy && !bus.fun_busy) begin
          w_state_nxt = S_DONE;
        end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        if (!r_res_valid || bus.res_ready) begin
          w_load      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // r_wdog counts cycles elapsed since the start pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_a       <= '0;
      r_cur_b       <= '0;
      r_seen_busy   <= 1'b0;
      r_wdog        <= '0;
      r_fun_start   <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_timeout_err <= 1'b0;
      r_jobs_done   <= '0;
    end else begin
      r_fun_start <= w_pop;
      if (w_pop) begin
        r_cur_a <= w_head.a;
        r_cur_b <= w_head.b;
      end
      if (r_state == S_LAUNCH) begin
        r_seen_busy <= 1'b0;
        r_wdog      <= WD_W'(1);
      end else if (r_state == S_RUN) begin
        if (bus.fun_busy) r_seen_busy <= 1'b1;
        r_wdog <= r_wdog + WD_W'(1);
      end
      if (w_abort) r_timeout_err <= 1'b1;
      if (w_load) begin
        r_res_data  <= bus.fun_result;
        r_res_valid <= 1'b1;
        r_jobs_done <= r_jobs_done + CNT_W'(1);
      end else if (bus.res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.fun_start = r_fun_start;
  assign bus.fun_a     = r_cur_a;
  assign bus.fun_b     = r_cur_b;
  assign timeout_err   = r_timeout_err;
  assign jobs_done     = r_jobs_done;
  assign fifo_level    = w_level;

endmodule
